etcpu_boot_ctrl: RTL and testbench
==================================

// Module: etcpu_boot_ctrl
// PURPOSE
//  Boot sequencer for the etcpu environment. Accepts a host word stream (valid/ready), writes it into
//  instruction memory at consecutive word addresses, and holds the CPU core in reset while it does so.
//  After the last word it releases the core reset following a fixed hold time.
//  Sits in etcpu_env_top between the host load port and the inst-mem write port / rst_n_cpu.
// PARAMETERS
//  INST_MEM_DEPTH  256      instruction memory depth in 32b words; max words per load
//  BASE_ADDR       32'h0    byte address of the first loaded word; must be word-aligned
//  RST_HOLD        4        cycles between the last write and CPU reset release; must be >=1
// PORTS
//  clk               in   1    clock
//  rst_n             in   1    async reset, active low
//  boot_start        in   1    level-sampled request to (re)load; acted on in IDLE/HOLD/RUN/ERR
//  ld_vld            in   1    host word valid
//  ld_rdy            out  1    controller ready; beat accepted when ld_vld&&ld_rdy
//  ld_dat            in   32   host instruction word
//  ld_last           in   1    qualifies the final beat of the load
//  inst_mem_wr_wen   out  1    inst-mem write enable, one-cycle pulse per accepted beat
//  inst_mem_wr_addr  out  32   byte address = BASE_ADDR + 4*word_idx
//  inst_mem_wr_dat   out  32   registered copy of ld_dat
//  cpu_rst_n         out  1    active-low reset to etcpu_top (drives rst_n_cpu)
//  busy              out  1    high in LOAD and HOLD
//  done              out  1    high in RUN
//  err               out  1    high in ERR (overflow)
//  word_cnt          out  $clog2(INST_MEM_DEPTH)+1   words written by the current/last load
// BEHAVIOUR
//  - Reset: state=IDLE; cpu_rst_n=0, ld_rdy=0, inst_mem_wr_wen=0, wr_addr=0, wr_dat=0,
//    busy=0, done=0, err=0, word_cnt=0. All outputs are registered.
//  - IDLE: cpu_rst_n=0. boot_start=1 -> LOAD; word_cnt cleared.
//  - LOAD: ld_rdy = (word_cnt < INST_MEM_DEPTH). An accepted beat at cycle N gives
//    inst_mem_wr_wen=1 at N+1 with addr BASE_ADDR+4*word_cnt(N) and dat ld_dat(N). word_cnt increments at N+1.
//    * Accepted beat with ld_last=1 -> HOLD at N+1. ld_rdy=0 from N+1.
//    * ld_vld=1 while word_cnt==INST_MEM_DEPTH -> ERR. The beat is not accepted and no write is issued.
//    * boot_start is ignored in LOAD.
//  - HOLD: cpu_rst_n stays 0. The down-counter is loaded with RST_HOLD on entry. The pending write
//    completes in the first HOLD cycle. cpu_rst_n=1 and done=1 at cycle N+1+RST_HOLD (N = last-beat cycle);
//    the state is RUN from then on.
//  - RUN: cpu_rst_n=1, ld_rdy=0. boot_start=1 -> LOAD with cpu_rst_n=0 the next cycle and word_cnt cleared.
//  - ERR: cpu_rst_n=0, err=1, word_cnt frozen. boot_start=1 -> LOAD, which clears err.
//  - boot_start=1 in HOLD aborts the release: LOAD next cycle, cpu_rst_n stays 0.
//  - Address arithmetic is 32-bit unsigned. word_idx never exceeds INST_MEM_DEPTH-1, so there is no wrap.
//  - inst_mem_wr_wen is never high outside the cycle after an accepted beat.
//  - cpu_rst_n is 0 in every cycle that inst_mem_wr_wen is 1.
//  - Async rst_n mid-load drops cpu_rst_n and ld_rdy immediately, kills any in-flight write and
//    returns to IDLE. A partial image is not resumed.
// STRUCTURE
//  - Package etcpu_boot_pkg: typedef enum {IDLE,LOAD,HOLD,RUN,ERR} boot_st_t; constant INST_W=32.
//  - Single module, no sub-modules. It holds one FSM, the word counter and the hold down-counter.
//  - etcpu_env_top instantiates it. inst_mem_wr_wen/addr/dat go to the existing inst-mem write mux;
//    cpu_rst_n drives rst_n_cpu.
// TESTING
//  1 Load 3 words (A,B,C; C with ld_last), BASE=0, RST_HOLD=4
//    -> wen pulses addr 0,4,8 with A,B,C; cpu_rst_n rises 5 cycles after the C beat; done=1; word_cnt=3.
//  2 ld_vld toggled randomly during load of 8 words
//    -> writes are contiguous addr 0..28, data in order, no extra wen pulses.
//  3 DEPTH=4, host sends 5 beats without ld_last
//    -> 4 writes at addr 0..12; 5th beat not accepted (ld_rdy=0); err=1; cpu_rst_n stays 0.
//  4 boot_start asserted in RUN, then 2 words loaded
//    -> cpu_rst_n=0 the next cycle; word_cnt restarts at 0; writes to addr 0,4; later released again.
//  5 boot_start during HOLD cycle 2
//    -> no release; LOAD entered; cpu_rst_n never pulses high.
//  6 rst_n asserted after the 2nd beat of a 6-word load
//    -> all outputs return to reset values asynchronously; no wen after reset; IDLE until boot_start.

Source files
------------

// File: rtl/etcpu_boot_pkg.sv
// Shared types for the etcpu boot sequencer: FSM state encoding and instruction word width.
package etcpu_boot_pkg;

  localparam int INST_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    ERR
  } boot_st_t;

endpackage

// File: rtl/etcpu_boot_ctrl.sv
// Boot sequencer: streams host words into instruction memory while holding the CPU in reset,
// then releases the core a fixed number of cycles after the last write.
module etcpu_boot_ctrl
  import etcpu_boot_pkg::*;
#(
  parameter int          INST_MEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          RST_HOLD       = 4,
  localparam int         CNT_W          = $clog2(INST_MEM_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_start,
  input  logic              ld_vld,
  output logic              ld_rdy,
  input  logic [INST_W-1:0] ld_dat,
  input  logic              ld_last,
  output logic              inst_mem_wr_wen,
  output logic [31:0]       inst_mem_wr_addr,
  output logic [INST_W-1:0] inst_mem_wr_dat,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  word_cnt
);

  // Load port handshake: a beat transfers on any rising clk edge where ld_vld && ld_rdy.
  // ld_rdy is registered and never depends on ld_vld in the same cycle.

  localparam int                HOLD_W    = $clog2(RST_HOLD + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(INST_MEM_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);

  boot_st_t          st, st_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              accept;
  logic              full;

  always_comb begin
    accept   = (st == LOAD) && ld_vld && ld_rdy;
    full     = (word_cnt == DEPTH_C);
    st_nxt   = st;
    cnt_nxt  = word_cnt;
    hold_nxt = hold_cnt;
    case (st)
      IDLE, RUN, ERR: begin
        if (boot_start) begin
          st_nxt  = LOAD;
          cnt_nxt = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_nxt = word_cnt + CNT_W'(1);
          if (ld_last) begin
            st_nxt   = HOLD;
            hold_nxt = HOLD_INIT;
          end
        end else if (ld_vld && full) begin
          st_nxt = ERR;
        end
      end
      HOLD: begin
        // A fresh request wins over a release that would happen this cycle.
        if (boot_start) begin
          st_nxt  = LOAD;
          cnt_nxt = '0;
        end else if (hold_cnt == '0) begin
          st_nxt = RUN;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st               <= IDLE;
      word_cnt         <= '0;
      hold_cnt         <= '0;
      ld_rdy           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      cpu_rst_n        <= 1'b0;
      inst_mem_wr_wen  <= 1'b0;
      inst_mem_wr_addr <= '0;
      inst_mem_wr_dat  <= '0;
    end else begin
      st              <= st_nxt;
      word_cnt        <= cnt_nxt;
      hold_cnt        <= hold_nxt;
      ld_rdy          <= (st_nxt == LOAD) && (cnt_nxt < DEPTH_C);
      busy            <= (st_nxt == LOAD) || (st_nxt == HOLD);
      done            <= (st_nxt == RUN);
      err             <= (st_nxt == ERR);
      cpu_rst_n       <= (st_nxt == RUN);
      inst_mem_wr_wen <= accept;
      if (accept) begin
        inst_mem_wr_addr <= BASE_ADDR + (32'(word_cnt) << 2);
        inst_mem_wr_dat  <= ld_dat;
      end
    end
  end

endmodule

// File: tb/tb_etcpu_boot_ctrl.sv
// Bench for etcpu_boot_ctrl: per-cycle vector table for the load/hold/release flow, plus
// hand-written overflow, random-valid, and async-reset sequences; writes go through a scoreboard.
module tb_etcpu_boot_ctrl;

  localparam int          DEPTH = 8;
  localparam int          HOLD  = 4;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          boot_start;
  logic          ld_vld;
  logic          ld_rdy;
  logic [31:0]   ld_dat;
  logic          ld_last;
  logic          inst_mem_wr_wen;
  logic [31:0]   inst_mem_wr_addr;
  logic [31:0]   inst_mem_wr_dat;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] word_cnt;

  etcpu_boot_ctrl #(
    .INST_MEM_DEPTH(DEPTH),
    .BASE_ADDR     (BASE),
    .RST_HOLD      (HOLD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .boot_start      (boot_start),
    .ld_vld          (ld_vld),
    .ld_rdy          (ld_rdy),
    .ld_dat          (ld_dat),
    .ld_last         (ld_last),
    .inst_mem_wr_wen (inst_mem_wr_wen),
    .inst_mem_wr_addr(inst_mem_wr_addr),
    .inst_mem_wr_dat (inst_mem_wr_dat),
    .cpu_rst_n       (cpu_rst_n),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .word_cnt        (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          bs;
    logic          vld;
    logic          last;
    logic [31:0]   dat;
    logic          rdy;
    logic          busy;
    logic          done;
    logic          err;
    logic          crn;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t        tbl[24];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          m_cnt   = 0;
  logic [63:0] exp_q[$];

  task automatic set_v(input int i, input logic bs, vld, last, input logic [31:0] dat,
                       input logic rdy, bsy, dn, er, crn, input logic [CW-1:0] cnt);
    tbl[i] = '{bs, vld, last, dat, rdy, bsy, dn, er, crn, cnt};
  endtask

  // Write-port scoreboard, sampled on the falling edge.
  task automatic mon();
    logic [63:0] e;
    if (inst_mem_wr_wen === 1'b1) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL wr_unexpected: got addr=%h dat=%h, want no write",
                 inst_mem_wr_addr, inst_mem_wr_dat);
      end else begin
        e = exp_q.pop_front();
        if ({inst_mem_wr_addr, inst_mem_wr_dat} !== e) begin
          err_cnt++;
          $display("FAIL wr_data: got addr=%h dat=%h, want addr=%h dat=%h",
                   inst_mem_wr_addr, inst_mem_wr_dat, e[63:32], e[31:0]);
        end
      end
      vec_cnt++;
      if (cpu_rst_n !== 1'b0) begin
        err_cnt++;
        $display("FAIL wr_cpu_rst: got cpu_rst_n=%b during write, want 0", cpu_rst_n);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge; push the write it must cause when accepted.
  task automatic cyc(input logic bs, vld, last, input logic [31:0] dat, input bit acc);
    boot_start = bs;
    ld_vld     = vld;
    ld_last    = last;
    ld_dat     = dat;
    if (bs) m_cnt = 0;
    if (acc) begin
      exp_q.push_back({BASE + 32'(m_cnt * 4), dat});
      m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    mon();
  endtask

  task automatic check_st(input string nm, input logic e_rdy, e_busy, e_done, e_err, e_crn,
                          input logic [CW-1:0] e_cnt);
    vec_cnt++;
    if ({ld_rdy, busy, done, err, cpu_rst_n, word_cnt} !==
        {e_rdy, e_busy, e_done, e_err, e_crn, e_cnt}) begin
      err_cnt++;
      $display("FAIL %s: got rdy=%b busy=%b done=%b err=%b cpu_rst_n=%b cnt=%0d, want rdy=%b busy=%b done=%b err=%b cpu_rst_n=%b cnt=%0d",
               nm, ld_rdy, busy, done, err, cpu_rst_n, word_cnt,
               e_rdy, e_busy, e_done, e_err, e_crn, e_cnt);
    end
  endtask

  task automatic check_wr_zero(input string nm);
    vec_cnt++;
    if ({inst_mem_wr_wen, inst_mem_wr_addr, inst_mem_wr_dat} !== 65'b0) begin
      err_cnt++;
      $display("FAIL %s: got wen=%b addr=%h dat=%h, want all zero",
               nm, inst_mem_wr_wen, inst_mem_wr_addr, inst_mem_wr_dat);
    end
  endtask

  initial begin
    int n;
    int sent;
    int guard;
    logic v;

    // 3-word load, release, reload from RUN, then abort during HOLD cycle 2.
    //          bs  vld last dat            rdy bsy dn er crn cnt
    set_v( 0, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0);
    set_v( 1, 0, 1, 0, 32'hA0A0_0001,  1, 1, 0, 0, 0, 1);
    set_v( 2, 0, 1, 0, 32'hB0B0_0002,  1, 1, 0, 0, 0, 2);
    set_v( 3, 0, 1, 1, 32'hC0C0_0003,  0, 1, 0, 0, 0, 3);
    set_v( 4, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 3);
    set_v( 5, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 3);
    set_v( 6, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 3);
    set_v( 7, 0, 0, 0, 32'h0,          0, 0, 1, 0, 1, 3);
    set_v( 8, 0, 0, 0, 32'h0,          0, 0, 1, 0, 1, 3);
    set_v( 9, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0);
    set_v(10, 0, 1, 0, 32'hD0D0_0004,  1, 1, 0, 0, 0, 1);
    set_v(11, 0, 1, 1, 32'hE0E0_0005,  0, 1, 0, 0, 0, 2);
    set_v(12, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 2);
    set_v(13, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 2);
    set_v(14, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 2);
    set_v(15, 0, 0, 0, 32'h0,          0, 0, 1, 0, 1, 2);
    set_v(16, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0);
    set_v(17, 0, 1, 1, 32'hF0F0_0006,  0, 1, 0, 0, 0, 1);
    set_v(18, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 1);
    set_v(19, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0);
    set_v(20, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0);
    set_v(21, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0);
    set_v(22, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0);
    set_v(23, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0);

    rst_n = 1'b0;
    repeat (2) cyc(0, 0, 0, 32'h0, 0);
    check_st("reset", 0, 0, 0, 0, 0, 0);
    check_wr_zero("reset_wr");
    rst_n = 1'b1;
    cyc(0, 0, 0, 32'h0, 0);
    check_st("idle", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].bs, tbl[i].vld, tbl[i].last, tbl[i].dat, tbl[i].vld);
      check_st($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].busy, tbl[i].done,
               tbl[i].err, tbl[i].crn, tbl[i].cnt);
    end

    // Overflow: DEPTH beats fill memory, one more without ld_last must trip ERR.
    for (int k = 0; k < DEPTH; k++) cyc(0, 1, 0, 32'h5500_0000 + 32'(k), 1);
    check_st("full", 0, 1, 0, 0, 0, CW'(DEPTH));
    cyc(0, 1, 0, 32'hDEAD_BEEF, 0);
    check_st("overflow", 0, 0, 0, 1, 0, CW'(DEPTH));
    cyc(0, 1, 0, 32'hDEAD_BEEF, 0);
    cyc(0, 0, 0, 32'h0, 0);
    check_st("err_hold", 0, 0, 0, 1, 0, CW'(DEPTH));
    cyc(1, 0, 0, 32'h0, 0);
    check_st("err_reload", 1, 1, 0, 0, 0, 0);

    // Random ld_vld gaps over an 8-word load.
    sent  = 0;
    guard = 0;
    while (sent < 8) begin
      v = (guard > 100) ? 1'b1 : 1'($urandom_range(0, 1));
      guard++;
      if (v) begin
        cyc(0, 1, (sent == 7), $urandom, 1);
        sent++;
      end else begin
        cyc(0, 0, 0, 32'h0, 0);
      end
    end
    n = 1;
    while (cpu_rst_n !== 1'b1 && n < 20) begin
      cyc(0, 0, 0, 32'h0, 0);
      n++;
    end
    vec_cnt++;
    if (n != HOLD + 1) begin
      err_cnt++;
      $display("FAIL release_latency: got %0d cycles, want %0d", n, HOLD + 1);
    end
    check_st("run_rand", 0, 0, 1, 0, 1, 8);

    // Async reset with the second beat's write in flight.
    cyc(1, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h6000_0001, 1);
    boot_start = 1'b0;
    ld_vld     = 1'b1;
    ld_last    = 1'b0;
    ld_dat     = 32'h6000_0002;
    @(posedge clk);
    #1 rst_n   = 1'b0;
    ld_vld     = 1'b0;
    #1;
    check_st("async_rst", 0, 0, 0, 0, 0, 0);
    check_wr_zero("async_rst_wr");
    @(negedge clk);
    mon();
    repeat (2) cyc(0, 0, 0, 32'h0, 0);
    rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0, 32'h0, 0);
    check_st("idle_after_rst", 0, 0, 0, 0, 0, 0);
    check_wr_zero("idle_after_rst_wr");

    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL sb_drain: got %0d writes outstanding, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
